// File: rtl/vend_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// vend_pkg : coin codes, coin values, default price/timeout and the
//            change-dispenser state encoding, shared across the vending blocks.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
package vend_pkg;

  localparam logic [1:0] COIN_NONE    = 2'b00;
  localparam logic [1:0] COIN_NICKEL  = 2'b01;
  localparam logic [1:0] COIN_DIME    = 2'b10;
  localparam logic [1:0] COIN_QUARTER = 2'b11;

  localparam logic [5:0] VAL_NICKEL  = 6'd5;
  localparam logic [5:0] VAL_DIME    = 6'd10;
  localparam logic [5:0] VAL_QUARTER = 6'd25;

  localparam int DEFAULT_PRICE   = 25;
  localparam int DEFAULT_TIMEOUT = 255;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEL      = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_WAIT_REL = 3'd3,
    ST_DONE     = 3'd4,
    ST_FAULT    = 3'd5
  } state_e;

  function automatic logic [5:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_NICKEL:  return VAL_NICKEL;
      COIN_DIME:    return VAL_DIME;
      COIN_QUARTER: return VAL_QUARTER;
      default:      return 6'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/hop_timeout_ctr.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// hop_timeout_ctr : clear/enable cycle counter that flags when it reaches
//                   TIMEOUT; holds there until cleared.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module hop_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != LIMIT))
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule
`default_nettype wire

// File: rtl/vend_change_dispenser.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// vend_change_dispenser : pays out (number_c - PRICE) one coin at a time over
//   a four-phase req/ack hopper handshake with per-phase timeout.
//   Define CHANGE_QUARTER_EN to allow quarters in the payout.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module vend_change_dispenser
  import vend_pkg::*;
#(
  parameter int PRICE   = DEFAULT_PRICE,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       candy,
  input  logic [5:0] number_c,
  input  logic       hop_ack,
  output logic       hop_req,
  output logic [1:0] hop_coin,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic       overrun,
  output logic [5:0] remain
);

  localparam logic [5:0] PRICE_C = PRICE[5:0];

  state_e     state_q, state_d;
  logic       hop_req_q, hop_req_d;
  logic [1:0] hop_coin_q, hop_coin_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       fault_q, fault_d;
  logic       overrun_q, overrun_d;
  logic [5:0] remain_q, remain_d;
  logic       tmr_clr, tmr_en, tmr_expired;
  logic [1:0] sel_code;

  hop_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmr (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  // Largest dispensable coin not exceeding what is still owed.
  always_comb begin
    sel_code = COIN_NONE;
`ifdef CHANGE_QUARTER_EN
    if (remain_q >= VAL_QUARTER)
      sel_code = COIN_QUARTER;
    else
`endif
    if (remain_q >= VAL_DIME)
      sel_code = COIN_DIME;
    else if (remain_q >= VAL_NICKEL)
      sel_code = COIN_NICKEL;
  end

  always_comb begin
    state_d    = state_q;
    hop_req_d  = hop_req_q;
    hop_coin_d = hop_coin_q;
    done_d     = 1'b0;
    fault_d    = fault_q;
    overrun_d  = overrun_q;
    remain_d   = remain_q;
    tmr_clr    = 1'b0;
    tmr_en     = 1'b0;

    if (candy && (state_q != ST_IDLE) && (state_q != ST_FAULT))
      overrun_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (candy) begin
          remain_d = (number_c >= PRICE_C) ? (number_c - PRICE_C) : 6'd0;
          state_d  = ST_SEL;
        end
      end
      ST_SEL: begin
        // A sub-nickel residue cannot be paid; it stays visible on remain.
        if (sel_code == COIN_NONE) begin
          state_d = ST_DONE;
        end else begin
          hop_coin_d = sel_code;
          hop_req_d  = 1'b1;
          tmr_clr    = 1'b1;
          state_d    = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (hop_ack) begin
          hop_req_d = 1'b0;
          remain_d  = remain_q - coin_value(hop_coin_q);
          tmr_clr   = 1'b1;
          state_d   = ST_WAIT_REL;
        end else if (tmr_expired) begin
          fault_d    = 1'b1;
          hop_req_d  = 1'b0;
          hop_coin_d = COIN_NONE;
          state_d    = ST_FAULT;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_WAIT_REL: begin
        if (!hop_ack) begin
          hop_coin_d = COIN_NONE;
          state_d    = ST_SEL;
        end else if (tmr_expired) begin
          fault_d    = 1'b1;
          hop_req_d  = 1'b0;
          hop_coin_d = COIN_NONE;
          state_d    = ST_FAULT;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      hop_req_q  <= 1'b0;
      hop_coin_q <= COIN_NONE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      overrun_q  <= 1'b0;
      remain_q   <= 6'd0;
    end else begin
      state_q    <= state_d;
      hop_req_q  <= hop_req_d;
      hop_coin_q <= hop_coin_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fault_q    <= fault_d;
      overrun_q  <= overrun_d;
      remain_q   <= remain_d;
    end
  end

  assign hop_req  = hop_req_q;
  assign hop_coin = hop_coin_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign fault    = fault_q;
  assign overrun  = overrun_q;
  assign remain   = remain_q;

endmodule
`default_nettype wire

// File: tb/tb_vend_change_dispenser.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_vend_change_dispenser : directed bench with a coin/remain scoreboard
//   and an in-line four-phase hopper responder.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_vend_change_dispenser;

  localparam int TIMEOUT = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       candy = 1'b0;
  logic [5:0] number_c = 6'd0;
  logic       hop_ack = 1'b0;
  logic       hop_req;
  logic [1:0] hop_coin;
  logic       busy, done, fault, overrun;
  logic [5:0] remain;

  int n_chk = 0;
  int n_fail = 0;
  int exp_code[$];
  int exp_rem[$];

  vend_change_dispenser dut (
    .clk      (clk),
    .rst      (rst),
    .candy    (candy),
    .number_c (number_c),
    .hop_ack  (hop_ack),
    .hop_req  (hop_req),
    .hop_coin (hop_coin),
    .busy     (busy),
    .done     (done),
    .fault    (fault),
    .overrun  (overrun),
    .remain   (remain)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int r);
`ifdef CHANGE_QUARTER_EN
    if (r >= 25) return 25;
`endif
    if (r >= 10) return 10;
    if (r >= 5)  return 5;
    return 0;
  endfunction

  function automatic int code_of(input int v);
    if (v == 25) return 3;
    if (v == 10) return 2;
    if (v == 5)  return 1;
    return 0;
  endfunction

  // Drive one candy pulse; optionally load the scoreboard with the payout.
  task automatic do_sale(input int num, input bit push);
    int r;
    int v;
    r = (num >= 25) ? num - 25 : 0;
    if (push) begin
      v = pick(r);
      while (v != 0) begin
        exp_code.push_back(code_of(v));
        exp_rem.push_back(r - v);
        r = r - v;
        v = pick(r);
      end
    end
    @(negedge clk);
    number_c = 6'(num);
    candy    = 1'b1;
    @(negedge clk);
    candy = 1'b0;
    chk("accept_remain", remain, (num >= 25) ? num - 25 : 0);
    chk("accept_busy", busy, 1);
  endtask

  task automatic wait_req(input string tag);
    int k = 0;
    while (!hop_req && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk(tag, hop_req, 1);
  endtask

  // Hopper responder: acks each coin, checks it against the scoreboard.
  task automatic serve(input string tag);
    bit got_done = 1'b0;
    int cyc = 0;
    int c, r, k;
    while (!got_done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        got_done = 1'b1;
      end else if (hop_req) begin
        if (exp_code.size() == 0) begin
          chk({tag, "_unexpected_req"}, hop_req, 0);
          cyc = 200;
        end else begin
          c = exp_code.pop_front();
          r = exp_rem.pop_front();
          chk({tag, "_coin"}, hop_coin, c);
          hop_ack = 1'b1;
          k = 0;
          do begin
            @(negedge clk);
            k++;
          end while (hop_req && k < 50);
          chk({tag, "_req_drop"}, hop_req, 0);
          chk({tag, "_remain"}, remain, r);
          hop_ack = 1'b0;
        end
      end
    end
    chk({tag, "_done_seen"}, got_done, 1);
    chk({tag, "_sb_empty"}, exp_code.size(), 0);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    int n;

    // Reset state
    #1;
    chk("rst_req", hop_req, 0);
    chk("rst_coin", hop_coin, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fault", fault, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_remain", remain, 0);
    @(negedge clk);
    rst = 1'b1;

    // Exact price: no coins, done two cycles after candy
    do_sale(25, 1'b0);
    chk("p25_done_c0", done, 0);
    @(negedge clk);
    chk("p25_done_c1", done, 0);
    chk("p25_req_c1", hop_req, 0);
    @(negedge clk);
    chk("p25_done_c2", done, 1);
    chk("p25_busy_c2", busy, 0);
    chk("p25_remain", remain, 0);
    @(negedge clk);
    chk("p25_done_pulse", done, 0);

    // 15c change
    do_sale(40, 1'b1);
    serve("p40");

    // 35c change
    do_sale(60, 1'b1);
    serve("p60");

    // Candy while waiting for ack: overrun, payout unchanged
    do_sale(40, 1'b1);
    wait_req("ovr_req");
    number_c = 6'd60;
    candy    = 1'b1;
    @(negedge clk);
    candy = 1'b0;
    chk("ovr_flag", overrun, 1);
    chk("ovr_req_held", hop_req, 1);
    serve("ovr");
    chk("ovr_sticky", overrun, 1);

    // Asynchronous reset in WAIT_REL
    do_sale(40, 1'b0);
    wait_req("arst_req");
    hop_ack = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_req_low", hop_req, 0);
    chk("arst_coin", hop_coin, 0);
    chk("arst_busy", busy, 0);
    chk("arst_overrun", overrun, 0);
    chk("arst_remain", remain, 0);
    hop_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Underpay after reset: done with no coins
    do_sale(20, 1'b1);
    serve("p20");

    // Hopper never acks: fault TIMEOUT+1 cycles after request
    do_sale(40, 1'b0);
    wait_req("to_req");
    n = 0;
    while (!fault && n < TIMEOUT + 20) begin
      @(negedge clk);
      n++;
    end
    chk("to_latency", n, TIMEOUT + 1);
    chk("to_req_low", hop_req, 0);
    chk("to_coin", hop_coin, 0);
    number_c = 6'd40;
    candy    = 1'b1;
    @(negedge clk);
    candy = 1'b0;
    repeat (4) @(negedge clk);
    chk("to_ign_req", hop_req, 0);
    chk("to_ign_fault", fault, 1);
    chk("to_ign_done", done, 0);
    chk("to_ign_busy", busy, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
